// File: rtl/pc_sequencer_pkg.sv
// Shared CPU configuration for the fetch PC sequencer: default widths,
// reset vector and the state / redirect-source enumerations.
package cpu_configuration;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } pc_seq_state_e;

  typedef enum logic [1:0] {
    NONE,
    DEC,
    EX,
    TRAP
  } redir_src_e;

endpackage

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Fixed-priority redirect select (trap > execute > decode); the losing
// sources are simply dropped, nothing is queued.
module redirect_arbiter
  import cpu_configuration::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            dec_valid_i,
  input  logic [XLEN-1:0] dec_target_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  output logic            valid_o,
  output logic [XLEN-1:0] target_o,
  output redir_src_e      src_o
);

  always_comb begin
    valid_o  = 1'b0;
    target_o = '0;
    src_o    = NONE;
    if (trap_valid_i) begin
      valid_o  = 1'b1;
      target_o = trap_target_i;
      src_o    = TRAP;
    end else if (ex_valid_i) begin
      valid_o  = 1'b1;
      target_o = ex_target_i;
      src_o    = EX;
    end else if (dec_valid_i) begin
      valid_o  = 1'b1;
      target_o = dec_target_i;
      src_o    = DEC;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, epoch and in-flight count and issues
// valid/ready fetch requests. Define PC_SEQ_ALIGN_CHECK_EN to reject
// misaligned redirect targets instead of forcing them to word alignment.
module pc_sequencer
  import cpu_configuration::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_addr,
  output logic            fetch_epoch,
  input  logic            fetch_ready,
  input  logic            rsp_valid,
  input  logic            rsp_epoch,
  output logic            rsp_keep,
  input  logic            stall_i,
  input  logic            dec_redir_valid,
  input  logic [XLEN-1:0] dec_redir_target,
  input  logic            ex_redir_valid,
  input  logic [XLEN-1:0] ex_redir_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] cur_pc
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

  pc_seq_state_e   state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic [2:0]      outstanding_q, outstanding_d;
  logic            flush_q, flush_d;
  logic            misalign_d;

  logic            arbValid;
  logic [XLEN-1:0] arbTarget;
  redir_src_e      arbSrc;
  logic            fire;
  logic            rspDec;
  logic            redirTake;
  logic            redirBad;
  logic [XLEN-1:0] redirTarget;

  redirect_arbiter #(.XLEN(XLEN)) u_arbiter (
    .dec_valid_i   (dec_redir_valid),
    .dec_target_i  (dec_redir_target),
    .ex_valid_i    (ex_redir_valid),
    .ex_target_i   (ex_redir_target),
    .trap_valid_i  (trap_valid),
    .trap_target_i (trap_vector),
    .valid_o       (arbValid),
    .target_o      (arbTarget),
    .src_o         (arbSrc)
  );

  assign fetch_valid = (state_q == RUN);
  assign fetch_addr  = pc_q;
  assign fetch_epoch = epoch_q;
  assign cur_pc      = pc_q;
  assign flush_o     = flush_q;
  assign rsp_keep    = rsp_valid && (rsp_epoch == epoch_q);
  assign fire        = fetch_valid && fetch_ready;
  assign rspDec      = rsp_valid && (outstanding_q != 3'd0);
  assign redirTake   = arbValid && (arbSrc != NONE) && (state_q != BOOT);

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign redirTarget = arbTarget;
  assign redirBad    = redirTake && (arbTarget[1:0] != 2'b00);
`else
  assign redirTarget = arbTarget & ~XLEN'(3);
  assign redirBad    = 1'b0;
`endif

  always_comb begin
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    outstanding_d = outstanding_q;
    flush_d       = 1'b0;
    misalign_d    = redirBad;
    state_d       = state_q;

    // A redirect wins over the sequential increment even when a fire happens.
    if (redirTake && !redirBad) begin
      pc_d    = redirTarget;
      epoch_d = ~epoch_q;
      flush_d = 1'b1;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(4);
    end

    case ({fire, rspDec})
      2'b10:   outstanding_d = outstanding_q + 3'd1;
      2'b01:   outstanding_d = outstanding_q - 3'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // Decide on the next count so a full window drops valid on the next cycle.
    case (state_q)
      BOOT:      state_d = RUN;
      RUN, HOLD: state_d = (stall_i || outstanding_d == MaxOut) ? HOLD : RUN;
      default:   state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      epoch_q       <= 1'b0;
      outstanding_q <= 3'd0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      outstanding_q <= outstanding_d;
      flush_q       <= flush_d;
    end
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a cycle-level
// behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;

  localparam int MAXO = 2;

  typedef struct packed {
    logic        rst;
    logic        ready;
    logic        rspValid;
    logic        rspEpoch;
    logic        stall;
    logic        decValid;
    logic [31:0] decTarget;
    logic        exValid;
    logic [31:0] exTarget;
    logic        trapValid;
    logic [31:0] trapTarget;
  } stim_t;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_epoch;
  logic        fetch_ready;
  logic        rsp_valid;
  logic        rsp_epoch;
  logic        rsp_keep;
  logic        stall_i;
  logic        dec_redir_valid;
  logic [31:0] dec_redir_target;
  logic        ex_redir_valid;
  logic [31:0] ex_redir_target;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        flush_o;
  logic        misalign_o;
  logic [31:0] cur_pc;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] mPc;
  bit          mEpoch;
  int          mCnt;
  bit          mBoot;
  bit          mIssue;
  bit          mFlush;
  bit          mMis;
  bit          mKnown = 0;

  logic        lastValid;
  logic [31:0] lastAddr;
  logic        lastEpoch;
  logic        lastFlush;
  logic        lastMis;
  logic        lastKeep;

  pc_sequencer #(
    .XLEN            (32),
    .RESET_VECTOR    (32'h0),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_addr       (fetch_addr),
    .fetch_epoch      (fetch_epoch),
    .fetch_ready      (fetch_ready),
    .rsp_valid        (rsp_valid),
    .rsp_epoch        (rsp_epoch),
    .rsp_keep         (rsp_keep),
    .stall_i          (stall_i),
    .dec_redir_valid  (dec_redir_valid),
    .dec_redir_target (dec_redir_target),
    .ex_redir_valid   (ex_redir_valid),
    .ex_redir_target  (ex_redir_target),
    .trap_valid       (trap_valid),
    .trap_vector      (trap_vector),
    .flush_o          (flush_o),
    .misalign_o       (misalign_o),
    .cur_pc           (cur_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.ready = 1'b1;
    return s;
  endfunction

  // One clock edge of the reference behaviour, applied to the inputs of that cycle.
  task automatic modelStep(input stim_t s);
    bit          fire;
    bit          have;
    bit          take;
    bit          bad;
    logic [31:0] tgt;
    fire = mIssue && s.ready;
    if (s.rst) begin
      mPc = 32'h0; mEpoch = 0; mCnt = 0; mBoot = 1; mIssue = 0;
      mFlush = 0; mMis = 0; mKnown = 1;
      return;
    end
    have = 1; tgt = 32'h0;
    if (s.trapValid)     tgt = s.trapTarget;
    else if (s.exValid)  tgt = s.exTarget;
    else if (s.decValid) tgt = s.decTarget;
    else                 have = 0;
    take = have && !mBoot;
    bad  = 0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    bad = take && (tgt % 4 != 0);
`else
    tgt = tgt & ~32'd3;
`endif
    mFlush = 0;
    if (take && !bad) begin
      mPc = tgt; mEpoch = !mEpoch; mFlush = 1;
    end else if (fire) begin
      mPc = mPc + 32'd4;
    end
    mMis = bad;
    if (s.rspValid && mCnt > 0) mCnt--;
    if (fire) mCnt++;
    if (mBoot) begin
      mBoot = 0; mIssue = 1;
    end else begin
      mIssue = !(s.stall || mCnt >= MAXO);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    bit expKeep;
    @(negedge clk);
    rst              = s.rst;
    fetch_ready      = s.ready;
    rsp_valid        = s.rspValid;
    rsp_epoch        = s.rspEpoch;
    stall_i          = s.stall;
    dec_redir_valid  = s.decValid;
    dec_redir_target = s.decTarget;
    ex_redir_valid   = s.exValid;
    ex_redir_target  = s.exTarget;
    trap_valid       = s.trapValid;
    trap_vector      = s.trapTarget;
    #1;
    lastValid = fetch_valid; lastAddr = fetch_addr; lastEpoch = fetch_epoch;
    lastFlush = flush_o; lastMis = misalign_o; lastKeep = rsp_keep;
    if (mKnown) begin
      expKeep = s.rspValid && (s.rspEpoch == mEpoch);
      checkOutput("fetch_valid", 32'(fetch_valid), 32'(mIssue));
      checkOutput("fetch_addr",  fetch_addr,       mPc);
      checkOutput("cur_pc",      cur_pc,           mPc);
      checkOutput("fetch_epoch", 32'(fetch_epoch), 32'(mEpoch));
      checkOutput("flush_o",     32'(flush_o),     32'(mFlush));
      checkOutput("misalign_o",  32'(misalign_o),  32'(mMis));
      checkOutput("rsp_keep",    32'(rsp_keep),    32'(expKeep));
    end
    @(posedge clk);
    modelStep(s);
  endtask

  initial begin
    stim_t       s;
    logic [31:0] t;
    bit          seen;

    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // Boot cycle, then back-to-back sequential fetches
    s = idleStim(); s.rspValid = 1'b1;
    applyStimulus(s); checkOutput("boot_valid", 32'(lastValid), 32'd0);
    applyStimulus(s); checkOutput("seq_addr0", lastAddr, 32'h0);
    checkOutput("seq_valid0", 32'(lastValid), 32'd1);
    applyStimulus(s); checkOutput("seq_addr1", lastAddr, 32'h4);
    applyStimulus(s); checkOutput("seq_addr2", lastAddr, 32'h8);
    checkOutput("seq_epoch", 32'(lastEpoch), 32'd0);

    // Wrap at the top of the address space
    s.exValid = 1'b1; s.exTarget = 32'hFFFF_FFFC;
    applyStimulus(s);
    s = idleStim(); s.rspValid = 1'b1;
    applyStimulus(s); checkOutput("wrap_pre_addr", lastAddr, 32'hFFFF_FFFC);
    checkOutput("wrap_epoch", 32'(lastEpoch), 32'd1);
    applyStimulus(s); checkOutput("wrap_addr", lastAddr, 32'h0);

    // Trap beats execute redirect
    s.trapValid = 1'b1; s.trapTarget = 32'h100;
    s.exValid = 1'b1; s.exTarget = 32'h200;
    applyStimulus(s);
    s = idleStim();
    applyStimulus(s); checkOutput("prio_addr", lastAddr, 32'h100);
    checkOutput("prio_flush", 32'(lastFlush), 32'd1);
    checkOutput("prio_epoch", 32'(lastEpoch), 32'd0);
    s.ready = 1'b0; s.rspValid = 1'b1;
    applyStimulus(s); checkOutput("prio_flush_end", 32'(lastFlush), 32'd0);
    applyStimulus(s);
    applyStimulus(s);

    // Fill the window, redirect in HOLD, stale response
    s = idleStim();
    applyStimulus(s); checkOutput("fill_v0", 32'(lastValid), 32'd1);
    applyStimulus(s); checkOutput("fill_v1", 32'(lastValid), 32'd1);
    applyStimulus(s); checkOutput("fill_drop", 32'(lastValid), 32'd0);
    s.trapValid = 1'b1; s.trapTarget = 32'h300;
    applyStimulus(s);
    s = idleStim(); s.rspValid = 1'b1; s.rspEpoch = 1'b0;
    applyStimulus(s); checkOutput("stale_keep", 32'(lastKeep), 32'd0);
    checkOutput("stale_valid", 32'(lastValid), 32'd0);
    s.rspEpoch = 1'b1;
    applyStimulus(s); checkOutput("refill_valid", 32'(lastValid), 32'd1);
    checkOutput("refill_addr", lastAddr, 32'h300);
    checkOutput("fresh_keep", 32'(lastKeep), 32'd1);

    // Misaligned execute target
    s = idleStim(); s.ready = 1'b0; s.exValid = 1'b1; s.exTarget = 32'h102;
    applyStimulus(s);
    s = idleStim(); s.ready = 1'b0;
    applyStimulus(s);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    checkOutput("mis_pulse", 32'(lastMis), 32'd1);
    checkOutput("mis_noflush", 32'(lastFlush), 32'd0);
    checkOutput("mis_pc", lastAddr, 32'h304);
`else
    checkOutput("mis_pulse", 32'(lastMis), 32'd0);
    checkOutput("mis_flush", 32'(lastFlush), 32'd1);
    checkOutput("mis_pc", lastAddr, 32'h100);
`endif

    // Stall with a decode jump arriving mid-stall
    s = idleStim(); s.stall = 1'b1;
    applyStimulus(s);
    s.rspValid = 1'b1; s.decValid = 1'b1; s.decTarget = 32'h40;
    applyStimulus(s); checkOutput("stall_v0", 32'(lastValid), 32'd0);
    s.decValid = 1'b0;
    applyStimulus(s); checkOutput("stall_v1", 32'(lastValid), 32'd0);
    s.stall = 1'b0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      applyStimulus(s);
      if (lastValid === 1'b1) seen = 1;
    end
    checkOutput("stall_resume_seen", 32'(seen), 32'd1);
    checkOutput("stall_resume_addr", lastAddr, 32'h40);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst      = ($urandom_range(0, 59) == 0);
      s.ready    = ($urandom_range(0, 3) != 0);
      s.rspValid = ($urandom_range(0, 1) == 1);
      s.rspEpoch = 1'($urandom_range(0, 1));
      s.stall    = ($urandom_range(0, 4) == 0);
      t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3;
      s.decValid = ($urandom_range(0, 9) == 0); s.decTarget = t;
      t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3;
      s.exValid = ($urandom_range(0, 9) == 0); s.exTarget = t;
      t = $urandom; if ($urandom_range(0, 3) != 0) t = t & ~32'd3;
      s.trapValid = ($urandom_range(0, 14) == 0); s.trapTarget = t;
      applyStimulus(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
